// File: rtl/vga_pkg.sv
// Shared 720p timing constants, pattern/direction types and the colour-bar palette
// for the VGA output stage.
package vga_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int BOX_EDGE = 64;
  localparam int BOX_MOVE = 4;

  typedef enum logic [1:0] {PAT_BARS, PAT_GRID, PAT_BOX, PAT_SOLID} pattern_e;
  typedef enum logic {DIR_INC, DIR_DEC} dir_e;
  typedef logic [11:0] rgb_t;

  // Ten 128-pixel bars; anything past the last bar is black.
  function automatic rgb_t bar_color(input logic [3:0] idx);
    case (idx)
      4'd0:    return 12'hFFF;
      4'd1:    return 12'hFF0;
      4'd2:    return 12'h0FF;
      4'd3:    return 12'h0F0;
      4'd4:    return 12'hF0F;
      4'd5:    return 12'hF00;
      4'd6:    return 12'h00F;
      4'd7:    return 12'h000;
      4'd8:    return 12'h888;
      4'd9:    return 12'h444;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: ping-pongs between 0 and MAX in STEP increments,
// advancing once per frame tick.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int MAX  = H_ACTIVE - BOX_EDGE,
  parameter int STEP = BOX_MOVE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  output logic [10:0] pos
);

  dir_e        dir;
  logic [11:0] pos_inc;

  // One extra bit so the increment can never wrap before being compared to MAX.
  assign pos_inc = {1'b0, pos} + 12'(STEP);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir <= DIR_INC;
      pos <= '0;
    end else if (frame_tick) begin
      case (dir)
        DIR_INC: begin
          if (pos_inc >= 12'(MAX)) begin
            pos <= 11'(MAX);
            dir <= DIR_DEC;
          end else begin
            pos <= pos_inc[10:0];
          end
        end
        DIR_DEC: begin
          if (pos <= 11'(STEP)) begin
            pos <= '0;
            dir <= DIR_INC;
          end else begin
            pos <= pos - 11'(STEP);
          end
        end
        default: dir <= DIR_INC;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: registers the counter position, decodes syncs, generates a
// selectable test pattern and drives aligned sync/DE/RGB pins two clocks later.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int IMAGE_WIDTH   = H_ACTIVE,
  parameter int HFP_WIDTH     = H_FP,
  parameter int HSYNCH_WIDTH  = H_SYNC,
  parameter int HBP_WIDTH     = H_BP,
  parameter int IMAGE_HEIGHT  = V_ACTIVE,
  parameter int VFP_HEIGHT    = V_FP,
  parameter int VSYNCH_HEIGHT = V_SYNC,
  parameter int VBP_HEIGHT    = V_BP,
  parameter bit SYNC_POL      = 1'b1,
  parameter int BOX_SIZE      = BOX_EDGE,
  parameter int BOX_STEP      = BOX_MOVE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] H_pos,
  input  logic [31:0] V_pos,
  input  logic        valid_video,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int HS_START = IMAGE_WIDTH + HFP_WIDTH;
  localparam int HS_END   = HS_START + HSYNCH_WIDTH;
  localparam int H_TOTAL  = HS_END + HBP_WIDTH;
  localparam int VS_START = IMAGE_HEIGHT + VFP_HEIGHT;
  localparam int VS_END   = VS_START + VSYNCH_HEIGHT;
  localparam int V_TOTAL  = VS_END + VBP_HEIGHT;
  localparam int MAX_X    = IMAGE_WIDTH - BOX_SIZE;
  localparam int MAX_Y    = IMAGE_HEIGHT - BOX_SIZE;

  logic [31:0] h1, v1;
  logic        valid1, hs1, vs1;
  logic [1:0]  sel_meta, sel_sync;
  pattern_e    mode_q;
  logic        frame_tick;
  logic [10:0] box_x, box_y;
  logic        in_box;
  rgb_t        color;

  // Stage 1: capture position and decode sync windows (limited to the frame).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1     <= '0;
      v1     <= '0;
      valid1 <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
    end else begin
      h1     <= H_pos;
      v1     <= V_pos;
      valid1 <= valid_video;
      hs1    <= (H_pos >= 32'(HS_START)) && (H_pos < 32'(HS_END)) && (H_pos < 32'(H_TOTAL));
      vs1    <= (V_pos >= 32'(VS_START)) && (V_pos < 32'(VS_END)) && (V_pos < 32'(V_TOTAL));
    end
  end

  assign frame_tick = (v1 == 32'(IMAGE_HEIGHT)) && (h1 == '0);

  // The switches are asynchronous; mode only changes at the top of vertical blanking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_meta <= '0;
      sel_sync <= '0;
      mode_q   <= PAT_BARS;
    end else begin
      sel_meta <= pattern_sel;
      sel_sync <= sel_meta;
      if (frame_tick) mode_q <= pattern_e'(sel_sync);
    end
  end

  vga_box_mover #(.MAX(MAX_X), .STEP(BOX_STEP)) u_box_x (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .pos       (box_x)
  );

  vga_box_mover #(.MAX(MAX_Y), .STEP(BOX_STEP)) u_box_y (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .pos       (box_y)
  );

  assign in_box = (h1 >= 32'(box_x)) && (h1 < 32'(box_x) + 32'(BOX_SIZE)) &&
                  (v1 >= 32'(box_y)) && (v1 < 32'(box_y) + 32'(BOX_SIZE));

  // NOTE: color gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    color = 12'h000;
    unique case (mode_q)
      PAT_BARS:  color = bar_color(h1[10:7]);
      PAT_GRID:  color = ((h1[5:0] == 6'd0) || (v1[5:0] == 6'd0)) ? 12'hFFF : 12'h000;
      PAT_BOX:   color = in_box ? 12'hFFF : 12'h008;
      PAT_SOLID: color = 12'h0F0;
    endcase
  end

  // Stage 2: every pin comes straight from a flop, so syncs are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync              <= ~SYNC_POL;
      vsync              <= ~SYNC_POL;
      de                 <= 1'b0;
      {red, green, blue} <= '0;
    end else begin
      hsync              <= hs1 ? SYNC_POL : ~SYNC_POL;
      vsync              <= vs1 ? SYNC_POL : ~SYNC_POL;
      de                 <= valid1;
      {red, green, blue} <= valid1 ? color : 12'h000;
    end
  end

endmodule
